// File: rtl/swu_pkg.sv
// Shared definitions for the SWU constant-ROM read path.
package swu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } swu_state_t;

  localparam int SWU_DEPTH = 29;
  localparam int SWU_AW    = 5;
  localparam int SWU_DW    = 32;

endpackage

// File: rtl/swu_skid_fifo.sv
// Two-entry register FIFO; entry 0 is always the head so the output is
// stable until popped.
module swu_skid_fifo #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   occ
);

  logic [W-1:0] d0, d1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d0  <= '0;
      d1  <= '0;
      occ <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) d0 <= din;
          else             d1 <= din;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          d0  <= d1;
          occ <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd2) begin
            d0 <= d1;
            d1 <= din;
          end else begin
            d0 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout = d0;

endmodule

// File: rtl/swu_rom_reader.sv
// Streams ROM words 0..DEPTH-1 as a valid/ready stream with a last flag.
//   state | meaning
//   IDLE  | waiting for start
//   FETCH | issuing ROM reads while buffer space allows
//   DRAIN | all reads issued, waiting for the last handshake
//   DONE  | one-cycle done pulse
module swu_rom_reader
  import swu_pkg::*;
#(
  parameter int DEPTH = SWU_DEPTH,
  parameter int AW    = SWU_AW,
  parameter int DW    = SWU_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          rom_en,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic          busy,
  output logic          done
);

  localparam logic [AW:0]   DEPTH_M1  = (AW+1)'(DEPTH - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  swu_state_t    state, state_d;
  logic          rom_en_d;
  logic [AW-1:0] rom_addr_d;
  logic [AW:0]   issued, issued_d;
  logic          rd_pend, rd_last;
  logic          push, pop, pend_n, room;
  logic [1:0]    occ;
  logic [2:0]    occ_n;
  logic [DW:0]   head;

  swu_skid_fifo #(.W(DW + 1)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ({rd_last, rom_data}),
    .pop   (pop),
    .dout  (head),
    .occ   (occ)
  );

  assign m_valid = (occ != 2'd0);
  assign m_data  = head[DW-1:0];
  assign m_last  = head[DW];
  assign pop     = m_valid & m_ready;
  // The ROM holds its output while rom_en=0, so a returned word may wait
  // there until the buffer has room; a new read is only issued when the
  // word it displaces is guaranteed to be captured first.
  assign push    = rd_pend & ((occ != 2'd2) | pop);
  assign occ_n   = 3'(occ) + 3'(push) - 3'(pop);
  assign pend_n  = rom_en | (rd_pend & ~push);
  assign room    = (occ_n + {2'b00, pend_n}) < 3'd3;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    state_d    = state;
    rom_en_d   = 1'b0;
    rom_addr_d = rom_addr;
    issued_d   = issued;
    case (state)
      IDLE: begin
        if (start) begin
          state_d    = FETCH;
          rom_en_d   = 1'b1;
          rom_addr_d = '0;
          issued_d   = (AW+1)'(1);
        end
      end
      FETCH: begin
        if (room) begin
          rom_en_d   = 1'b1;
          rom_addr_d = issued[AW-1:0];
          issued_d   = issued + (AW+1)'(1);
          if (issued == DEPTH_M1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && m_last) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rom_en   <= 1'b0;
      rom_addr <= '0;
      issued   <= '0;
      rd_pend  <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      state    <= state_d;
      rom_en   <= rom_en_d;
      rom_addr <= rom_addr_d;
      issued   <= issued_d;
      rd_pend  <= pend_n;
      if (rom_en) rd_last <= (rom_addr == LAST_ADDR);
    end
  end

endmodule

// File: tb/tb_swu_rom_reader.sv
// Scoreboard bench for swu_rom_reader: DEPTH=29 main instance and a DEPTH=2 build.
module tb_swu_rom_reader;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic          start, start2;
  logic          rom_en, rom_en2;
  logic [AW-1:0] rom_addr, rom_addr2;
  logic [DW-1:0] rom_data, rom_data2;
  logic          m_valid, m_valid2;
  logic          m_ready, m_ready2;
  logic [DW-1:0] m_data, m_data2;
  logic          m_last, m_last2;
  logic          busy, busy2;
  logic          done, done2;

  swu_rom_reader #(.DEPTH(29), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .busy(busy), .done(done)
  );

  swu_rom_reader #(.DEPTH(2), .AW(AW), .DW(DW)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .rom_en(rom_en2), .rom_addr(rom_addr2),
    .rom_data(rom_data2), .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2),
    .m_last(m_last2), .busy(busy2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ROM models that hold their output while rom_en=0.
  initial begin rom_data = '0; rom_data2 = '0; end
  always @(posedge clk) if (rom_en)  rom_data  <= 32'hA500_0000 + 32'(rom_addr);
  always @(posedge clk) if (rom_en2) rom_data2 <= 32'hA500_0000 + 32'(rom_addr2);

  int chk_cnt = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  logic [DW:0] q[$];
  logic [DW:0] q2[$];
  time t_e0 = 0;
  int rel, rel2;
  int hs_cnt, first_hs, last_hs, done_cnt, done_cyc, busy_first, busy_fall, en_first;
  int max_occ = 0, pushfull = 0;
  logic [AW-1:0] en_first_addr;
  int hs2, first2, last2_cyc, done2_cnt, done2_cyc;
  logic [7:0] lfsr = 8'hB7;

  task automatic clear_stats();
    hs_cnt = 0; first_hs = -1; last_hs = -1; done_cnt = 0; done_cyc = -1;
    busy_first = -1; busy_fall = -1; en_first = -1; en_first_addr = '1;
  endtask

  always @(negedge clk) begin
    rel = int'(($time - t_e0 - 5) / 10) + 1;
    if (busy && busy_first < 0) busy_first = rel;
    if (!busy && busy_first >= 0 && busy_fall < 0) busy_fall = rel;
    if (rom_en && en_first < 0) begin en_first = rel; en_first_addr = rom_addr; end
    if (int'(dut.u_fifo.occ) > max_occ) max_occ = int'(dut.u_fifo.occ);
    if (dut.push && dut.u_fifo.occ == 2'd2 && !dut.pop) pushfull++;
    if (done) begin done_cnt++; done_cyc = rel; end
    if (m_valid && m_ready) begin
      if (q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_word: got 0x%0h, required no word", {m_last, m_data});
      end else begin
        check("stream_word", 64'({m_last, m_data}), 64'(q.pop_front()));
      end
      hs_cnt++;
      if (first_hs < 0) first_hs = rel;
      last_hs = rel;
    end
  end

  always @(negedge clk) begin
    rel2 = int'(($time - t_e0 - 5) / 10) + 1;
    if (done2) begin done2_cnt++; done2_cyc = rel2; end
    if (m_valid2 && m_ready2) begin
      if (q2.size() == 0) begin
        chk_cnt++;
        $display("FAIL d2_unexpected_word: got 0x%0h, required no word", {m_last2, m_data2});
      end else begin
        check("d2_stream_word", 64'({m_last2, m_data2}), 64'(q2.pop_front()));
      end
      hs2++;
      if (first2 < 0) first2 = rel2;
      if (m_last2) last2_cyc = rel2;
    end
  end

  task automatic do_start();
    clear_stats();
    for (int i = 0; i < 29; i++) q.push_back({(i == 28), 32'hA500_0000 + 32'(i)});
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); t_e0 = $time;
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd, input string tag);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk); #1;
      if (rnd) begin
        lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        m_ready = lfsr[0];
      end
      n++;
    end
    if (done_cnt == 0) begin
      chk_cnt++;
      $display("FAIL %s_timeout: no done after %0d cycles, required done", tag, budget);
    end
    m_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outs(input string tag);
    check({tag, "_rom_en"},   64'(rom_en),   64'(0));
    check({tag, "_rom_addr"}, 64'(rom_addr), 64'(0));
    check({tag, "_m_valid"},  64'(m_valid),  64'(0));
    check({tag, "_m_data"},   64'(m_data),   64'(0));
    check({tag, "_m_last"},   64'(m_last),   64'(0));
    check({tag, "_busy"},     64'(busy),     64'(0));
    check({tag, "_done"},     64'(done),     64'(0));
  endtask

  initial begin
    int en_cnt, hold_bad, n;
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; m_ready = 1'b1; m_ready2 = 1'b1;
    hs2 = 0; first2 = -1; last2_cyc = -1; done2_cnt = 0; done2_cyc = -1;
    clear_stats();
    repeat (2) @(posedge clk);
    #1 check_zero_outs("reset");
    rst_n = 1'b1;

    // Full-rate run
    do_start();
    wait_done(100, 1'b0, "t1");
    check("t1_en_first_cycle", 64'(en_first), 64'(1));
    check("t1_en_first_addr", 64'(en_first_addr), 64'(0));
    check("t1_busy_rise", 64'(busy_first), 64'(1));
    check("t1_first_hs", 64'(first_hs), 64'(3));
    check("t1_last_hs", 64'(last_hs), 64'(31));
    check("t1_hs_count", 64'(hs_cnt), 64'(29));
    check("t1_done_cycle", 64'(done_cyc), 64'(32));
    check("t1_done_count", 64'(done_cnt), 64'(1));
    check("t1_busy_fall", 64'(busy_fall), 64'(33));
    check("t1_queue_empty", 64'(q.size()), 64'(0));

    // Backpressure for 10 cycles from the first m_valid
    m_ready = 1'b0;
    do_start();
    n = 0;
    while (!m_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("t2_first_valid_cycle", 64'(n), 64'(2));
    en_cnt = 0; hold_bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (rom_en) en_cnt++;
      if (!m_valid || m_data !== 32'hA500_0000 || m_last) hold_bad++;
    end
    check("t2_rom_en_le2", 64'(en_cnt <= 2), 64'(1));
    check("t2_head_hold", 64'(hold_bad), 64'(0));
    @(posedge clk); #1 m_ready = 1'b1;
    wait_done(100, 1'b0, "t2");
    check("t2_hs_count", 64'(hs_cnt), 64'(29));
    check("t2_queue_empty", 64'(q.size()), 64'(0));

    // Pseudo-random ready
    do_start();
    wait_done(400, 1'b1, "t3");
    check("t3_hs_count", 64'(hs_cnt), 64'(29));
    check("t3_queue_empty", 64'(q.size()), 64'(0));
    check("t3_max_occ_le2", 64'(max_occ <= 2), 64'(1));
    check("t3_push_when_full", 64'(pushfull), 64'(0));

    // Second start during a run is ignored
    do_start();
    repeat (9) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(100, 1'b0, "t4");
    repeat (5) @(posedge clk);
    #1;
    check("t4_hs_count", 64'(hs_cnt), 64'(29));
    check("t4_done_count", 64'(done_cnt), 64'(1));
    check("t4_queue_empty", 64'(q.size()), 64'(0));
    check("t4_idle_after", 64'(busy), 64'(0));

    // Asynchronous reset mid-run after word 10
    do_start();
    n = 0;
    while (hs_cnt < 11 && n < 50) begin @(posedge clk); #1; n++; end
    check("t5_reached_word10", 64'(hs_cnt), 64'(11));
    #1 rst_n = 1'b0;
    #1 check_zero_outs("t5_async");
    q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    do_start();
    wait_done(100, 1'b0, "t5");
    check("t5_first_hs", 64'(first_hs), 64'(3));
    check("t5_hs_count", 64'(hs_cnt), 64'(29));
    check("t5_queue_empty", 64'(q.size()), 64'(0));

    // DEPTH=2 build
    q2.push_back({1'b0, 32'hA500_0000});
    q2.push_back({1'b1, 32'hA500_0001});
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); t_e0 = $time;
    #1 start2 = 1'b0;
    n = 0;
    while (done2_cnt == 0 && n < 30) begin @(posedge clk); #1; n++; end
    repeat (3) @(posedge clk);
    #1;
    check("t6_hs_count", 64'(hs2), 64'(2));
    check("t6_first_hs", 64'(first2), 64'(3));
    check("t6_last_cycle", 64'(last2_cyc), 64'(4));
    check("t6_done_cycle", 64'(done2_cyc), 64'(5));
    check("t6_done_count", 64'(done2_cnt), 64'(1));
    check("t6_queue_empty", 64'(q2.size()), 64'(0));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/swu_rom_reader.md
# swu_rom_reader

Read-side sequencer for the sliding-window-unit (SWU) constant ROMs in the ECG accelerator. On a start pulse it walks the ROM address space from 0 to DEPTH-1, drives the ROM's `enable`/`addr` pins, and absorbs the ROM's one-cycle registered read latency. It presents the words as a valid/ready stream with a last flag and never loses or duplicates a word under backpressure. The block sits between a `swu_rom_*` instance and the SWU datapath.

## Interface
- `DEPTH`, 29: number of ROM words streamed per run; legal range is 2..32.
- `AW`, 5: ROM address width.
- `DW`, 32: ROM word width.
- `clk` input 1: single clock; all logic is rising-edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `start` input 1: one-cycle pulse that begins a run. It is ignored unless the block is in IDLE.
- `rom_en` output 1: ROM read enable, registered.
- `rom_addr` output AW: ROM read address, registered.
- `rom_data` input DW: ROM read data, valid one cycle after the cycle with `rom_en`=1. The ROM holds its output while `rom_en`=0.
- `m_valid` output 1: stream word available.
- `m_ready` input 1: consumer accepts the word.
- `m_data` output DW: stream word.
- `m_last` output 1: high with the word from address DEPTH-1.
- `busy` output 1: high from the cycle after `start` is accepted until `done`.
- `done` output 1: one-cycle pulse after the last handshake.

## Operation
- FSM states:
  - IDLE: `start` moves to FETCH, clears the address counter and clears the issued count.
  - FETCH: issues reads. When read DEPTH-1 has been issued, moves to DRAIN.
  - DRAIN: waits for the last stream handshake (`m_valid`&`m_ready`&`m_last`), then moves to DONE.
  - DONE: asserts `done` for one cycle, then returns to IDLE.
- Read issue in FETCH: `rom_en` is 1 in a cycle iff `occ + inflight - pop < 2`.
  - `occ` is the current buffer occupancy (0..2).
  - `inflight` is 1 if `rom_en` was 1 in the previous cycle.
  - `pop` is 1 if `m_valid`&`m_ready` this cycle.
  - `rom_addr` increments by 1 after each issued read and never exceeds DEPTH-1; there is no wrap.
- Capture: the cycle after each issued read, `rom_data` is written into the 2-entry buffer together with a last tag (address == DEPTH-1).
- Stream: `m_valid`, `m_data` and `m_last` come from the buffer head. `m_data` and `m_last` must stay stable while `m_valid`=1 and `m_ready`=0.
- Simultaneous push and pop keeps occupancy unchanged. Push into a full buffer cannot occur by construction; the bench asserts this.
- `start` in any non-IDLE state is ignored with no side effects.
- Asynchronous reset, including mid-run, forces:
  - state to IDLE;
  - buffer cleared;
  - outputs to `rom_en`=0, `rom_addr`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `busy`=0, `done`=0.
- The stale in-flight ROM word is discarded.

## Timing
- `start` is sampled at edge E0. `rom_en`=1 with `rom_addr`=0 holds in cycle 1. `rom_data`[0] is present in cycle 2 and is captured at E2. `m_valid` is first high in cycle 3.
- Start-to-first-word latency is 3 cycles.
- With `m_ready` held at 1, one word per cycle is delivered in cycles 3..DEPTH+2. `m_last` is in cycle DEPTH+2, `done` in cycle DEPTH+3, and `busy` falls in cycle DEPTH+4.
- With `m_ready`=0, at most 2 reads are outstanding or buffered beyond the head. `rom_en` drops within 1 cycle.
- After `m_ready` returns to 1, the stream resumes the same cycle from the buffer head with no bubble if occupancy is 2.

## Structure
- Shared package `swu_pkg` holds:
  - the FSM state enum (IDLE, FETCH, DRAIN, DONE);
  - localparams for the default DEPTH, AW and DW, shared with the `swu_rom_*` modules.
- Sub-module `swu_skid_fifo` is a 2-entry, DW+1-bit wide register FIFO with push, pop, occupancy and async active-low clear. It is the only sub-module.

## Test plan
- ROM is preloaded with word i = 0xA5000000+i, DEPTH=29, `m_ready`=1, one `start` pulse. Required response:
  - 29 handshakes in cycles 3..31 carrying words 0..28 in order;
  - `m_last` only on 0xA500001C;
  - `done` in cycle 32, `busy` low in cycle 33.
- `m_ready`=0 for 10 cycles after the first `m_valid`, then 1. Required response:
  - `rom_en` is high for at most 2 more cycles;
  - `m_data` holds 0xA5000000 throughout;
  - all 29 words arrive in order with none dropped or duplicated.
- `m_ready` toggled pseudo-randomly (LFSR, 50%). Required response:
  - the in-order sequence 0..28 is delivered;
  - buffer occupancy never exceeds 2;
  - push-when-full never fires.
- `start` pulsed again at cycle 10 of a run. Required response: it is ignored; exactly 29 words and one `done`.
- `rst_n` asserted asynchronously mid-cycle after word 10. Required response:
  - all outputs read 0 immediately;
  - a following `start` streams from 0xA5000000 with the same 3-cycle latency.
- DEPTH=2 build. Required response: words 0 and 1, `m_last` on word 1, `done` 1 cycle later.
